// File: rtl/alu_dot8_pipe.sv
// rtl/alu_dot8_pipe.sv - pipelined signed INT8 4-way dot-product PE with elastic valid/ready stages
module alu_dot8_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [NUM_LANES-1:0]      out_mask,
  output logic [NUM_LANES*XLEN-1:0] out_data,
  output logic                      busy
);

  localparam int DW = NUM_LANES * XLEN;

  logic [LATENCY:1]                v_q;
  logic [LATENCY:1]                ld;
  logic [NUM_LANES-1:0][3:0][15:0] prod_d;
  logic [NUM_LANES-1:0][3:0][15:0] prod_q;
  logic [TAG_WIDTH-1:0]            tag1_q;
  logic [NUM_LANES-1:0]            mask1_q;
  logic [TAG_WIDTH-1:0]            tag_q  [LATENCY:2];
  logic [NUM_LANES-1:0]            mask_q [LATENCY:2];
  logic [DW-1:0]                   data_q [LATENCY:2];
  logic [DW-1:0]                   sum_d;

  // A stage may load when it is empty or its occupant leaves this cycle;
  // the "open" chain ripples from the output back toward the input.
  always_comb begin : advance
    logic open;
    ld   = '0;
    open = !v_q[LATENCY] || out_ready;
    ld[LATENCY] = open;
    for (int i = LATENCY - 1; i >= 1; i--) begin
      open  = !v_q[i] || open;
      ld[i] = open;
    end
  end

  always_comb begin : products
    logic signed [15:0] a;
    logic signed [15:0] b;
    a      = '0;
    b      = '0;
    prod_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < 4; k++) begin
        a = {{8{in_rs1[l*XLEN + 8*k + 7]}}, in_rs1[l*XLEN + 8*k +: 8]};
        b = {{8{in_rs2[l*XLEN + 8*k + 7]}}, in_rs2[l*XLEN + 8*k +: 8]};
        // Masked lanes carry zero products so their sum is zero downstream.
        if (in_mask[l]) prod_d[l][k] = a * b;
      end
    end
  end

  always_comb begin : summation
    logic [17:0] acc;
    acc   = '0;
    sum_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        acc = acc + {{2{prod_q[l][k][15]}}, prod_q[l][k]};
      end
      sum_d[l*XLEN +: XLEN] = {{(XLEN-18){acc[17]}}, acc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      prod_q  <= '0;
      tag1_q  <= '0;
      mask1_q <= '0;
      for (int i = 2; i <= LATENCY; i++) begin
        tag_q[i]  <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (ld[1]) v_q[1] <= in_valid;
      if (ld[1] && in_valid) begin
        prod_q  <= prod_d;
        tag1_q  <= in_tag;
        mask1_q <= in_mask;
      end
      if (ld[2]) v_q[2] <= v_q[1];
      if (ld[2] && v_q[1]) begin
        tag_q[2]  <= tag1_q;
        mask_q[2] <= mask1_q;
        data_q[2] <= sum_d;
      end
      for (int i = 3; i <= LATENCY; i++) begin
        if (ld[i]) v_q[i] <= v_q[i-1];
        if (ld[i] && v_q[i-1]) begin
          tag_q[i]  <= tag_q[i-1];
          mask_q[i] <= mask_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign in_ready  = ld[1];
  assign out_valid = v_q[LATENCY];
  assign out_tag   = tag_q[LATENCY];
  assign out_mask  = mask_q[LATENCY];
  assign out_data  = data_q[LATENCY];
  assign busy      = |v_q;

endmodule

// File: tb/tb_alu_dot8_pipe.sv
// tb/tb_alu_dot8_pipe.sv - scoreboard bench for alu_dot8_pipe with a dot-product reference model
module tb_alu_dot8_pipe;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_tag = '0;
  logic [3:0]   in_mask = '0;
  logic [127:0] in_rs1 = '0;
  logic [127:0] in_rs2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_tag;
  logic [3:0]   out_mask;
  logic [127:0] out_data;
  logic         busy;

  alu_dot8_pipe #(.NUM_LANES(4), .XLEN(32), .TAG_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_mask(in_mask),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_mask(out_mask), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           n_out = 0;
  logic [139:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic         rdone = 1'b0;
  logic [139:0] prev_out;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Per lane: sum of four signed byte products, zero when the lane is masked off.
  function automatic logic [127:0] dot_model(input logic [3:0] m, input logic [127:0] a,
                                             input logic [127:0] b);
    logic [127:0]      r;
    logic signed [7:0] x;
    logic signed [7:0] y;
    int                s;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        x = a[l*32 + 8*k +: 8];
        y = b[l*32 + 8*k +: 8];
        s += int'(x) * int'(y);
      end
      if (m[l]) r[l*32 +: 32] = s;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_stable", {out_tag, out_mask, out_data}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got tag %h with empty scoreboard", out_tag);
        end else begin
          chk("scoreboard", {out_tag, out_mask, out_data}, exp_q.pop_front());
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_tag, out_mask, out_data};
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, in_mask, dot_model(in_mask, in_rs1, in_rs2)});
    end
  end

  task automatic send(input logic [7:0] t, input logic [3:0] m, input logic [127:0] a,
                      input logic [127:0] b, output int waits);
    in_tag = t; in_mask = m; in_rs1 = a; in_rs2 = b; in_valid = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: tag %h not accepted", t);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output logic [7:0] t, output logic [3:0] m, output logic [127:0] d);
    int k;
    k = 0; t = '0; m = '0; d = '0;
    while (1) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        t = out_tag; m = out_mask; d = out_data;
        break;
      end
      k++;
      if (k > 50) begin
        checks++;
        failures++;
        $display("FAIL wait_out_timeout: no output within bound");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int           w;
    int           n;
    int           n0;
    logic         acc;
    logic [7:0]   t;
    logic [3:0]   m;
    logic [127:0] d;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);

    // single request, fixed latency
    out_ready = 1'b1;
    send(8'h5A, 4'h1, {{3{32'h11223344}}, 32'h04030201}, {4{32'h01010101}}, w);
    in_valid = 1'b0;
    chk("lat_stage1_only", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1);
    wait_out(t, m, d);
    chk("single_data", d, {96'h0, 32'd10});
    chk("single_tag", t, 8'h5A);

    // sign extremes
    send(8'h01, 4'hF, {4{32'h80808080}}, {4{32'h80808080}}, w);
    send(8'h02, 4'hF, {4{32'h80808080}}, {4{32'h7F7F7F7F}}, w);
    in_valid = 1'b0;
    wait_out(t, m, d);
    chk("neg_times_neg", d, {4{32'h00010000}});
    wait_out(t, m, d);
    chk("neg_times_pos", d, {4{32'hFFFF0200}});

    // back-to-back
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 4'hF, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, w);
      chk("b2b_in_ready", w, 0);
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", n_out - n0, 8);

    // mask
    send(8'h09, 4'b1010, {4{32'h01010101}}, {4{32'h01010101}}, w);
    in_valid = 1'b0;
    wait_out(t, m, d);
    chk("mask_data", d, {32'd4, 32'd0, 32'd4, 32'd0});
    chk("mask_bits", m, 4'b1010);

    // backpressure
    out_ready = 1'b0;
    n = 0;
    n0 = n_out;
    in_tag = 8'h20; in_mask = 4'hF; in_valid = 1'b1;
    in_rs1 = {$urandom, $urandom, $urandom, $urandom};
    in_rs2 = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        in_tag = 8'(8'h20 + n);
        in_rs1 = {$urandom, $urandom, $urandom, $urandom};
        in_rs2 = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk("bp_accepted", n, LAT);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pass_through", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_drain_count", n_out - n0, LAT + 1);

    // reset with entries in flight
    out_ready = 1'b0;
    send(8'h40, 4'hF, {4{32'h01020304}}, {4{32'h05060708}}, w);
    send(8'h41, 4'hF, {4{32'h01020304}}, {4{32'h05060708}}, w);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_output", n_out - n0, 0);
    send(8'h42, 4'hF, {4{32'hFF01FF01}}, {4{32'h02020202}}, w);
    in_valid = 1'b0;
    wait_out(t, m, d);
    chk("post_rst_tag", t, 8'h42);

    // randomized traffic with random backpressure
    fork
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(8'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, w);
    end
    in_valid = 1'b0;
    rdone = 1'b1;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
